// File: rtl/grid_bank_arbiter_pkg.sv
// grid_bank_arbiter_pkg: shared grid row-vector width, grid constants and collision-pointer encodings.
`ifndef GRID_VEC_ALIGN_N
`define GRID_VEC_ALIGN_N 8
`endif
package grid_bank_arbiter_pkg;
    localparam int GRID_VEC_W = `GRID_VEC_ALIGN_N;
    localparam int GRID_ROWS = 32;
    typedef logic [GRID_VEC_W-1:0] row_vec_t;
    localparam logic [0:0] PTR_WRITE = 1'b0;
    localparam logic [0:0] PTR_READ = 1'b1;
endpackage

// File: rtl/single_port_sync_ram.sv
// single_port_sync_ram: one RAM bank, single port, registered read data, contents never reset.
module single_port_sync_ram #(
    parameter int WIDTH = 8,
    parameter int ADDR_WIDTH = 4
)(
    input  logic                  clock,
    input  logic                  bank_en,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      write_data,
    output logic [WIDTH-1:0]      read_data
);
    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clock)
        if (bank_en) begin
            if (write_en) mem[addr] <= write_data;
            else read_data <= mem[addr];
        end
endmodule

// File: rtl/grid_bank_arbiter.sv
// grid_bank_arbiter: shares N_BANKS interleaved RAM banks between a row writer and a row reader.
// Define AOC4_ARB_RR_EN for round-robin same-bank collisions; otherwise the write always wins.
module grid_bank_arbiter
    import grid_bank_arbiter_pkg::*;
#(
    parameter int N_BANKS = 2,
    parameter int BANK_ADDR_WIDTH = 4,
    parameter int BANK_DEPTH = 16,
    localparam int BW = $clog2(N_BANKS),
    localparam int ADDR_WIDTH = BANK_ADDR_WIDTH + BW
)(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [`GRID_VEC_ALIGN_N-1:0] wr_data,
    input  logic                         rd_valid,
    output logic                         rd_ready,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic                         rsp_valid,
    output logic [ADDR_WIDTH-1:0]        rsp_addr,
    output logic [`GRID_VEC_ALIGN_N-1:0] rsp_data
);
    localparam logic [BANK_ADDR_WIDTH-1:0] LAST_ROW = BANK_ADDR_WIDTH'(BANK_DEPTH - 1);
    logic [BW-1:0] wr_bank, rd_bank, rsp_bank;
    logic [BANK_ADDR_WIDTH-1:0] wr_row, rd_row;
    logic collide, rd_wins, wr_go, rd_go, wr_in, rd_in, rsp_hit;
    row_vec_t read_data [N_BANKS];

    assign wr_bank = wr_addr[BW-1:0];
    assign rd_bank = rd_addr[BW-1:0];
    assign wr_row = wr_addr[ADDR_WIDTH-1:BW];
    assign rd_row = rd_addr[ADDR_WIDTH-1:BW];
    assign wr_in = wr_row <= LAST_ROW;
    assign rd_in = rd_row <= LAST_ROW;
    assign collide = wr_valid && rd_valid && wr_bank == rd_bank;

`ifdef AOC4_ARB_RR_EN
    logic ptr;
    // the collision winner hands priority to the other side for the next collision
    always_ff @(posedge clock or posedge reset)
        if (reset) ptr <= PTR_WRITE;
        else if (collide) ptr <= ~ptr;
    assign rd_wins = ptr == PTR_READ;
`else
    assign rd_wins = 1'b0;
`endif

    assign wr_ready = !reset && !(collide && rd_wins);
    assign rd_ready = !reset && !(collide && !rd_wins);
    assign wr_go = wr_valid && wr_ready;
    assign rd_go = rd_valid && rd_ready;

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic wr_hit, rd_hit;
        assign wr_hit = wr_go && wr_in && wr_bank == BW'(b);
        assign rd_hit = rd_go && rd_in && rd_bank == BW'(b);
        single_port_sync_ram #(.WIDTH(GRID_VEC_W), .ADDR_WIDTH(BANK_ADDR_WIDTH)) u_ram (
            .clock      (clock),
            .bank_en    (wr_hit || rd_hit),
            .write_en   (wr_hit),
            .addr       (wr_hit ? wr_row : rd_row),
            .write_data (wr_data),
            .read_data  (read_data[b])
        );
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_addr <= '0;
            rsp_bank <= '0;
            rsp_hit <= 1'b0;
        end else begin
            rsp_valid <= rd_go;
            if (rd_go) begin
                rsp_addr <= rd_addr;
                rsp_bank <= rd_bank;
                rsp_hit <= rd_in;
            end
        end

    // out-of-range reads never touched a bank, so their response is forced to zero
    assign rsp_data = (rsp_valid && rsp_hit) ? read_data[rsp_bank] : '0;
endmodule

// File: tb/tb_grid_bank_arbiter.sv
// tb_grid_bank_arbiter: directed vector table plus hand sequences for collisions, depth limit and reset.
module tb_grid_bank_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic wr_valid = 1'b0, rd_valid = 1'b0;
    logic [4:0] wr_addr = '0, rd_addr = '0;
    logic [7:0] wr_data = '0;
    logic wr_ready, rd_ready, rsp_valid;
    logic [4:0] rsp_addr;
    logic [7:0] rsp_data;
    logic d8_wr_ready, d8_rd_ready, d8_rsp_valid;
    logic [4:0] d8_rsp_addr;
    logic [7:0] d8_rsp_data;
    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    grid_bank_arbiter dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data)
    );

    grid_bank_arbiter #(.BANK_DEPTH(8)) dut8 (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(d8_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(d8_rd_ready), .rd_addr(rd_addr),
        .rsp_valid(d8_rsp_valid), .rsp_addr(d8_rsp_addr), .rsp_data(d8_rsp_data)
    );

    typedef struct {
        logic wv; logic [4:0] wa; logic [7:0] wd;
        logic rv; logic [4:0] ra;
        logic ewr; logic erd; logic ev; logic [4:0] ea; logic [7:0] ed;
    } vec_t;

    vec_t tbl [14];
    logic [7:0] sd [8];
    logic ew [3];
    logic er [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [4:0] wa, input logic [7:0] wd, input logic rv, input logic [4:0] ra);
        wr_valid = wv; wr_addr = wa; wr_data = wd; rd_valid = rv; rd_addr = ra;
    endtask

    initial begin
        sd = '{8'h00, 8'h11, 8'h22, 8'hA5, 8'h5A, 8'h55, 8'h66, 8'h77};
        tbl[0] = '{1'b1, 5'h03, 8'hA5, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 5'h00, 8'h00};
        tbl[1] = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h03, 1'b0, 1'b1, 1'b1, 5'h03, 8'hA5};
        tbl[2] = '{1'b1, 5'h04, 8'h5A, 1'b1, 5'h05, 1'b1, 1'b1, 1'b1, 5'h05, 8'h55};
        tbl[3] = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h04, 1'b0, 1'b1, 1'b1, 5'h04, 8'h5A};
        tbl[4] = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h1F, 1'b0, 1'b1, 1'b1, 5'h1F, 8'hF0};
        tbl[5] = '{1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00};
        for (int i = 0; i < 8; i++)
            tbl[6+i] = '{1'b0, 5'h00, 8'h00, 1'b1, 5'(i), 1'b0, 1'b1, 1'b1, 5'(i), sd[i]};
`ifdef AOC4_ARB_RR_EN
        ew = '{1'b1, 1'b0, 1'b1};
        er = '{1'b0, 1'b1, 1'b0};
`else
        ew = '{1'b1, 1'b1, 1'b1};
        er = '{1'b0, 1'b0, 1'b0};
`endif

        // reset state, with both requesters asking
        drive(1'b1, 5'h00, 8'h00, 1'b1, 5'h01);
        #1;
        chk("reset_wr_ready", 32'(wr_ready), 32'd0);
        chk("reset_rd_ready", 32'(rd_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_addr", 32'(rsp_addr), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        drive(1'b0, 5'h00, 8'h00, 1'b0, 5'h00);
        cyc();
        reset = 1'b0;
        cyc();

        // prefill rows 0x00..0x07, 0x0F and 0x1F
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(i), 8'(i * 8'h11), 1'b0, 5'h00);
            #1 chk("fill_wr_ready", 32'(wr_ready), 32'd1);
            cyc();
        end
        drive(1'b1, 5'h0F, 8'hC3, 1'b0, 5'h00);
        cyc();
        drive(1'b1, 5'h1F, 8'hF0, 1'b0, 5'h00);
        #1 chk("oor_wr_ready_d8", 32'(d8_wr_ready), 32'd1);
        cyc();

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra);
            #1;
            if (tbl[i].wv) chk($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'(tbl[i].ewr));
            if (tbl[i].rv) chk($sformatf("vec%0d_rd_ready", i), 32'(rd_ready), 32'(tbl[i].erd));
            cyc();
            chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("vec%0d_rsp_addr", i), 32'(rsp_addr), 32'(tbl[i].ea));
            chk($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(tbl[i].ed));
        end

        // depth 8: row 15 is out of range, row 7 of the same bank is untouched
        drive(1'b0, 5'h00, 8'h00, 1'b1, 5'h1F);
        #1 chk("d8_oor_rd_ready", 32'(d8_rd_ready), 32'd1);
        cyc();
        chk("d8_oor_rsp_valid", 32'(d8_rsp_valid), 32'd1);
        chk("d8_oor_rsp_data", 32'(d8_rsp_data), 32'd0);
        chk("d16_1f_rsp_data", 32'(rsp_data), 32'hF0);
        drive(1'b0, 5'h00, 8'h00, 1'b1, 5'h0F);
        cyc();
        chk("d8_0f_rsp_data", 32'(d8_rsp_data), 32'hC3);
        chk("d16_0f_rsp_data", 32'(rsp_data), 32'hC3);

        // same-bank collision held for three cycles
        drive(1'b1, 5'h06, 8'hEE, 1'b1, 5'h08);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("coll%0d_wr_ready", k), 32'(wr_ready), 32'(ew[k]));
            chk($sformatf("coll%0d_rd_ready", k), 32'(rd_ready), 32'(er[k]));
            cyc();
            chk($sformatf("coll%0d_rsp_valid", k), 32'(rsp_valid), 32'(er[k]));
        end
        drive(1'b0, 5'h00, 8'h00, 1'b1, 5'h06);
        cyc();
        chk("coll_written_data", 32'(rsp_data), 32'hEE);

        // asynchronous reset with a read in flight
        drive(1'b0, 5'h00, 8'h00, 1'b1, 5'h01);
        cyc();
        drive(1'b0, 5'h00, 8'h00, 1'b1, 5'h02);
        #1;
        chk("pre_rst_rd_ready", 32'(rd_ready), 32'd1);
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pre_rst_rsp_data", 32'(rsp_data), 32'h11);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_rd_ready", 32'(rd_ready), 32'd0);
        drive(1'b0, 5'h00, 8'h00, 1'b0, 5'h00);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("post_rst%0d_rsp_valid", k), 32'(rsp_valid), 32'd0);
        end

        // after reset the write wins the first collision again
        drive(1'b1, 5'h00, 8'h00, 1'b1, 5'h02);
        #1;
        chk("post_rst_coll_wr_ready", 32'(wr_ready), 32'd1);
        chk("post_rst_coll_rd_ready", 32'(rd_ready), 32'd0);
        cyc();
        drive(1'b0, 5'h00, 8'h00, 1'b0, 5'h00);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/grid_bank_arbiter.md
Name: grid_bank_arbiter

Overview:
- Shares a banked grid-row store between two requesters: the input loader (writes) and the neighbour-count scanner (reads).
- Internally builds the store from N_BANKS single-port synchronous RAM banks, rows interleaved across banks.
- Per cycle: a write and a read to different banks are both granted; a same-bank collision is arbitrated.
- Returns read data with a registered valid, one cycle after the read handshake.

Parameters:
- N_BANKS, 2, number of RAM banks; power of two, ≥2.
- BANK_ADDR_WIDTH, 4, row-address bits inside one bank.
- BANK_DEPTH, 16, rows per bank; ≤ 2**BANK_ADDR_WIDTH.
- ADDR_WIDTH (localparam), BANK_ADDR_WIDTH + $clog2(N_BANKS), global row-address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  loader write request.
- wr_ready  out  1  write accepted this cycle; combinational.
- wr_addr  in  ADDR_WIDTH  global row address of the write.
- wr_data  in  `GRID_VEC_ALIGN_N  row vector to write.
- rd_valid  in  1  scanner read request.
- rd_ready  out  1  read accepted this cycle; combinational.
- rd_addr  in  ADDR_WIDTH  global row address of the read.
- rsp_valid  out  1  read data valid; registered.
- rsp_addr  out  ADDR_WIDTH  address of the returned row.
- rsp_data  out  `GRID_VEC_ALIGN_N  returned row vector.

Behaviour:
- Address split:
  - bank = addr[$clog2(N_BANKS)-1:0]
  - row = addr[ADDR_WIDTH-1:$clog2(N_BANKS)]
  - Consecutive rows therefore fall in different banks.
- Handshake:
  - A transfer occurs when valid && ready.
  - A requester holds valid, addr and data stable until ready.
  - ready never depends on the requester's own ready.
- No collision (requests to different banks, or only one valid): every valid request gets ready=1 in the same cycle.
- Collision (both valid, same bank): exactly one ready is asserted.
  - Default: write wins.
  - AOC4_ARB_RR_EN changes this; see Optional Feature.
- Bank drive:
  - Granted write: that bank gets bank_en=1, write_en=1, its row address and wr_data.
  - Granted read: that bank gets bank_en=1, write_en=0.
  - Ungranted banks get bank_en=0.
- Read latency:
  - Read handshake in cycle N gives rsp_valid=1 in cycle N+1, with rsp_addr = rd_addr of cycle N.
  - rsp_data is the selected bank's read_data, muxed by a registered bank index.
  - There is no response backpressure; the scanner must sink every response.
- Back-to-back reads: one per cycle, full throughput; rsp_valid stays high continuously.
- Read-after-write to the same address: a write in cycle N and a read handshake in cycle N+1 return the new data.
- Out-of-range row (row ≥ BANK_DEPTH): the request is accepted and the access is suppressed.
  - A write is dropped.
  - A read returns rsp_valid=1 with rsp_data=0.
- When rsp_valid=0, rsp_data is driven 0.
- Reset values:
  - rsp_valid=0, rsp_addr=0, rsp_data=0.
  - Round-robin pointer = write-first.
  - RAM contents are not reset.
- Reset mid-operation: an in-flight read is discarded and no response is produced after reset deasserts. ready outputs are 0 while reset is high.

Optional Feature:
- Macro: AOC4_ARB_RR_EN.
- Defined:
  - Collisions are decided by a 1-bit round-robin pointer: the winner of a collision loses the next collision.
  - The pointer updates only on collision cycles.
  - Guarantees no requester waits more than one collision cycle.
- Undefined:
  - Fixed priority, write always wins a collision.
  - No pointer register; the read may starve under continuous colliding writes.

Decomposition:
- Shared in aoc4.svh / aoc4 package:
  - `GRID_VEC_ALIGN_N
  - grid row-count constants
  - a typedef for the row vector
- Sub-module: N_BANKS instances of single_port_sync_ram, generated in a loop. This is the only natural sub-module.
- Arbitration and response tracking stay in this module.

Test Plan (N_BANKS=2, BANK_ADDR_WIDTH=4, widths per aoc4.svh):
1. Write 0x03 with data 0xA5 pattern, then read 0x03 next cycle -> rd_ready=1; one cycle later rsp_valid=1, rsp_addr=0x03, rsp_data=0xA5 pattern.
2. Same cycle, write 0x04 (bank 0) and read 0x05 (bank 1) -> wr_ready=1 and rd_ready=1; rsp_valid next cycle with the prior contents of 0x05.
3. Same cycle, write 0x06 and read 0x08 (both bank 0), held 3 cycles:
   - Without RR: wr_ready=1 each cycle, rd_ready=0.
   - With AOC4_ARB_RR_EN: grants alternate W, R, W.
4. Reads to 0x00..0x07 streamed one per cycle -> rd_ready=1 every cycle; 8 consecutive rsp_valid pulses starting one cycle after the first read; rsp_addr increments 0..7.
5. Read handshake on 0x02, reset asserted asynchronously mid-cycle before the next edge -> rsp_valid=0 immediately, and no rsp_valid after reset releases.
6. Read 0x1F (row 15, inside BANK_DEPTH=16) returns the stored data. Rebuild with BANK_DEPTH=8 and read 0x1F -> rsp_valid=1, rsp_data=0. A write to 0x1F is accepted and has no effect on stored data.
